sfp_link_sync_ctrl: RTL and testbench
=====================================

Name: sfp_link_sync_ctrl

Overview:
Link-synchronisation controller for the SFP receive path. Sits after the byte aligner and monitors the aligned 32-bit data and 4-bit K-flag stream. It declares link-up after a run of valid comma words, tracks errors while locked, and drops back to hunting when errors accumulate. If lock is not reached within a timeout, it issues a timed GT receive-reset request. Downstream video/packet logic gates on link_up.

Parameters:
COMMA, 8'hBC, K28.5 code expected in byte 0 of an idle word
LOCK_CNT, 16, consecutive valid comma words needed to declare lock (1..255)
ERR_LIMIT, 4, error-accumulator value that forces loss of lock (1..15)
DECAY_WORDS, 64, consecutive valid words that decrement the error accumulator by 1 (1..255)
TIMEOUT, 24'd1_000_000, rx_clk cycles allowed in HUNT/CHECK before a GT reset
RST_CYCLES, 32, width of the gt_rx_rst_req pulse in cycles (1..255)

Ports:
rx_clk  input  1  receive recovered clock; all logic on rising edge
i_chk_rstn  input  1  asynchronous active-low reset
gt_rx_ready  input  1  GT CDR/PLL ready; level, assumed synchronous to rx_clk
rx_data_align  input  32  byte-aligned receive data
rx_ctrl_align  input  4  byte-aligned K flags; bit n qualifies byte n
link_up  output  1  high while in LOCKED
gt_rx_rst_req  output  1  GT receive reset request, high for RST_CYCLES cycles
sync_state  output  3  current state encoding, for debug
realign_cnt  output  8  saturating count of LOCKED->HUNT transitions
gt_rst_cnt  output  8  saturating count of GT reset requests issued
err_acc  output  4  current error accumulator

Behaviour:
- Reset (async, i_chk_rstn=0): state=IDLE; all outputs 0; all internal counters 0.
- Word classification (combinational, on each rx_clk cycle):
  - comma: ctrl==4'b0001 and data[7:0]==COMMA.
  - data: ctrl==4'b0000.
  - valid = comma or data; invalid = any other ctrl pattern, or ctrl==0001 with byte0!=COMMA.
- States: IDLE=0, HUNT=1, CHECK=2, LOCKED=3, GTRST=4. Outputs are decoded from the state register: link_up=(state==LOCKED), gt_rx_rst_req=(state==GTRST). Transitions take effect on the edge that samples the qualifying word; link_up therefore rises the cycle after the LOCK_CNT-th comma is presented.
- IDLE: when gt_rx_ready=1, go to HUNT and clear tmo_cnt.
- HUNT: a comma loads comma_cnt=1 and moves to CHECK. If LOCK_CNT==1, a comma goes directly to LOCKED.
- CHECK:
  - A comma increments comma_cnt; when comma_cnt reaches LOCK_CNT, go to LOCKED and clear err_acc and good_run.
  - A data word holds comma_cnt.
  - An invalid word clears comma_cnt and returns to HUNT; tmo_cnt is not cleared.
- Timeout: tmo_cnt increments every cycle in HUNT/CHECK. When it reaches TIMEOUT-1, go to GTRST, load rst_cnt=0 and increment gt_rst_cnt (saturating at 255). Timeout takes priority over a lock in the same cycle.
- GTRST: rst_cnt increments each cycle; after RST_CYCLES cycles, go to IDLE. Input words are ignored in this state.
- LOCKED:
  - An invalid word increments err_acc (saturating at 15) and clears good_run.
  - A valid word increments good_run. When good_run reaches DECAY_WORDS, clear good_run and decrement err_acc if it is nonzero.
  - When err_acc+increment >= ERR_LIMIT, go to HUNT on that edge; increment realign_cnt (saturating at 255); clear err_acc, comma_cnt and tmo_cnt.
- gt_rx_ready=0 in any state except GTRST forces IDLE on the next edge and clears comma_cnt and tmo_cnt. It does not count as a realign. This has the highest priority.
- Reset mid-operation aborts any gt_rx_rst_req pulse immediately.
- Counter widths: comma_cnt 8b, good_run 8b, tmo_cnt 24b, rst_cnt 8b. No wrap is permitted; all saturate or clear as stated.

Test Plan:
- Reset then gt_rx_ready=1, feed 16 words {ctrl=0001, data=0x000000BC} -> link_up=0 through the 16th word, link_up=1 the next cycle, sync_state=3.
- After lock, feed 4 words with ctrl=0010 interleaved with 10 data words -> link_up drops on the 4th bad word's edge, realign_cnt=1, sync_state=1.
- In CHECK after 10 commas, inject 1 word with ctrl=0001, data[7:0]=0x3C -> back to HUNT, comma_cnt=0; 16 more commas are then needed to lock.
- TIMEOUT=100, gt_rx_ready=1, only data words -> gt_rx_rst_req high from cycle 101 for exactly 32 cycles, gt_rst_cnt=1, then IDLE->HUNT.
- Locked with DECAY_WORDS=64: 3 bad words, 64 good, 1 bad -> err_acc goes 3,2,3 and link_up stays 1; one further bad word -> loss of lock.
- Drop gt_rx_ready while LOCKED -> IDLE next cycle, link_up=0, realign_cnt unchanged; assert i_chk_rstn=0 during GTRST -> gt_rx_rst_req=0 immediately.

Source files
------------

// File: rtl/sfp_link_sync_ctrl.sv
// sfp_link_sync_ctrl: comma-based link lock/loss FSM with error decay and GT receive-reset timeout.
module sfp_link_sync_ctrl #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter int          LOCK_CNT    = 16,
  parameter int          ERR_LIMIT   = 4,
  parameter int          DECAY_WORDS = 64,
  parameter logic [23:0] TIMEOUT     = 24'd1_000_000,
  parameter int          RST_CYCLES  = 32
) (
  input  logic        rx_clk,
  input  logic        i_chk_rstn,
  input  logic        gt_rx_ready,
  input  logic [31:0] rx_data_align,
  input  logic [3:0]  rx_ctrl_align,
  output logic        link_up,
  output logic        gt_rx_rst_req,
  output logic [2:0]  sync_state,
  output logic [7:0]  realign_cnt,
  output logic [7:0]  gt_rst_cnt,
  output logic [3:0]  err_acc
);
  typedef enum logic [2:0] {IDLE, HUNT, CHECK, LOCKED, GTRST} state_t;
  state_t      state;
  logic [7:0]  comma_cnt, good_run, rst_cnt, cnt_nxt;
  logic [23:0] tmo_cnt;
  logic        is_comma, is_data, is_valid, tmo_hit, unused_data;
  logic [4:0]  err_next;
  assign is_comma    = rx_ctrl_align == 4'b0001 && rx_data_align[7:0] == COMMA;
  assign is_data     = rx_ctrl_align == 4'b0000;
  assign is_valid    = is_comma || is_data;
  assign err_next    = {1'b0, err_acc} + {4'b0, ~is_valid};
  assign tmo_hit     = tmo_cnt == TIMEOUT - 24'd1;
  // HUNT always restarts the run at 1, regardless of what an aborted run left behind
  assign cnt_nxt     = state == HUNT ? 8'd1 : comma_cnt + 8'd1;
  assign unused_data = ^rx_data_align[31:8];
  assign link_up       = state == LOCKED;
  assign gt_rx_rst_req = state == GTRST;
  assign sync_state    = state;
  always_ff @(posedge rx_clk or negedge i_chk_rstn) begin
    if (!i_chk_rstn) begin
      state       <= IDLE;
      comma_cnt   <= '0;
      good_run    <= '0;
      rst_cnt     <= '0;
      tmo_cnt     <= '0;
      realign_cnt <= '0;
      gt_rst_cnt  <= '0;
      err_acc     <= '0;
    end else if (!gt_rx_ready && state != GTRST) begin
      state     <= IDLE;
      comma_cnt <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state   <= HUNT;
          tmo_cnt <= '0;
        end
        HUNT, CHECK: begin
          if (tmo_hit) begin
            state      <= GTRST;
            rst_cnt    <= '0;
            comma_cnt  <= '0;
            gt_rst_cnt <= gt_rst_cnt == 8'hFF ? gt_rst_cnt : gt_rst_cnt + 8'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
            if (is_comma) begin
              comma_cnt <= cnt_nxt;
              state     <= cnt_nxt == 8'(LOCK_CNT) ? LOCKED : CHECK;
              if (cnt_nxt == 8'(LOCK_CNT)) begin
                err_acc  <= '0;
                good_run <= '0;
              end
            end else if (!is_data) begin
              state     <= HUNT;
              comma_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (err_next >= 5'(ERR_LIMIT)) begin
            state       <= HUNT;
            realign_cnt <= realign_cnt == 8'hFF ? realign_cnt : realign_cnt + 8'd1;
            err_acc     <= '0;
            comma_cnt   <= '0;
            tmo_cnt     <= '0;
            good_run    <= '0;
          end else if (!is_valid) begin
            err_acc  <= err_next[4] ? 4'hF : err_next[3:0];
            good_run <= '0;
          end else if (good_run == 8'(DECAY_WORDS - 1)) begin
            good_run <= '0;
            err_acc  <= err_acc == 4'd0 ? err_acc : err_acc - 4'd1;
          end else begin
            good_run <= good_run + 8'd1;
          end
        end
        GTRST: begin
          if (rst_cnt == 8'(RST_CYCLES - 1)) state <= IDLE;
          else rst_cnt <= rst_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sfp_link_sync_ctrl.sv
// tb_sfp_link_sync_ctrl: table-driven vectors for lock/loss/decay plus hand sequences for timeout and reset.
module tb_sfp_link_sync_ctrl;
  logic        clk = 0;
  logic        rstn = 0;
  logic        rdy = 0;
  logic [31:0] data = '0;
  logic [3:0]  ctrl = '0;
  logic        link_up, gt_rx_rst_req;
  logic [2:0]  sync_state;
  logic [7:0]  realign_cnt, gt_rst_cnt;
  logic [3:0]  err_acc;
  int          n_vec = 0;
  int          n_err = 0;
  typedef struct {
    logic        rdy;
    logic [3:0]  ctrl;
    logic [31:0] data;
    logic [24:0] exp;
  } vec_t;
  vec_t v[$];
  localparam logic [31:0] CD = 32'h0000_00BC;
  localparam logic [31:0] DD = 32'h1234_5678;

  sfp_link_sync_ctrl #(.TIMEOUT(24'd100)) dut (
    .rx_clk(clk), .i_chk_rstn(rstn), .gt_rx_ready(rdy),
    .rx_data_align(data), .rx_ctrl_align(ctrl),
    .link_up(link_up), .gt_rx_rst_req(gt_rx_rst_req), .sync_state(sync_state),
    .realign_cnt(realign_cnt), .gt_rst_cnt(gt_rst_cnt), .err_acc(err_acc)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] pk(logic l, logic r, logic [2:0] s, logic [7:0] ra, logic [7:0] g, logic [3:0] e);
    return {l, r, s, ra, g, e};
  endfunction

  task automatic add(logic r, logic [3:0] c, logic [31:0] d, logic l, logic [2:0] s, logic [7:0] ra, logic [3:0] e);
    v.push_back('{r, c, d, pk(l, 1'b0, s, ra, 8'd0, e)});
  endtask

  task automatic step(logic r, logic [3:0] c, logic [31:0] d);
    rdy = r; ctrl = c; data = d;
    @(posedge clk); #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    add(1, 4'h0, DD, 0, 1, 0, 0);
    for (int i = 1; i < 16; i++) add(1, 4'b0001, CD, 0, 2, 0, 0);
    add(1, 4'b0001, CD, 1, 3, 0, 0);
    add(1, 4'b0010, DD, 1, 3, 0, 1);
    for (int i = 0; i < 2; i++) add(1, 4'h0, DD, 1, 3, 0, 1);
    add(1, 4'b0010, DD, 1, 3, 0, 2);
    for (int i = 0; i < 3; i++) add(1, 4'h0, DD, 1, 3, 0, 2);
    add(1, 4'b0010, DD, 1, 3, 0, 3);
    for (int i = 0; i < 5; i++) add(1, 4'h0, DD, 1, 3, 0, 3);
    add(1, 4'b0010, DD, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) add(1, 4'b0001, CD, 0, 2, 1, 0);
    add(1, 4'b0001, 32'h0000_003C, 0, 1, 1, 0);
    for (int i = 1; i < 16; i++) add(1, 4'b0001, CD, 0, 2, 1, 0);
    add(1, 4'b0001, CD, 1, 3, 1, 0);
    add(1, 4'b1000, DD, 1, 3, 1, 1);
    add(1, 4'b0001, 32'h0000_003C, 1, 3, 1, 2);
    add(1, 4'b1111, DD, 1, 3, 1, 3);
    for (int i = 0; i < 63; i++) add(1, i[0] ? 4'b0001 : 4'h0, i[0] ? CD : DD, 1, 3, 1, 3);
    add(1, 4'h0, DD, 1, 3, 1, 2);
    add(1, 4'b0100, DD, 1, 3, 1, 3);
    add(1, 4'b0010, DD, 0, 1, 2, 0);
    for (int i = 1; i < 16; i++) add(1, 4'b0001, CD, 0, 2, 2, 0);
    add(1, 4'b0001, CD, 1, 3, 2, 0);
    add(0, 4'b0001, CD, 0, 0, 2, 0);
    add(1, 4'h0, DD, 0, 1, 2, 0);

    rstn = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {7'd0, link_up, gt_rx_rst_req, sync_state, realign_cnt, gt_rst_cnt, err_acc}, 32'd0);
    rstn = 1;
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rdy, v[i].ctrl, v[i].data);
      chk($sformatf("vec%0d", i), {7'd0, link_up, gt_rx_rst_req, sync_state, realign_cnt, gt_rst_cnt, err_acc}, {7'd0, v[i].exp});
    end

    n = 0;
    do begin step(1, 4'h0, DD); n++; end while (!gt_rx_rst_req && n < 200);
    chk("tmo_cycles", n, 100);
    chk("tmo_state", {29'd0, sync_state}, 4);
    chk("gt_rst_cnt1", {24'd0, gt_rst_cnt}, 1);
    chk("link_in_gtrst", {31'd0, link_up}, 0);
    n = 1;
    while (gt_rx_rst_req && n < 100) begin
      step(1, 4'b0010, DD);
      if (gt_rx_rst_req) n++;
    end
    chk("rst_width", n, 32);
    chk("post_rst_state", {29'd0, sync_state}, 0);
    step(1, 4'h0, DD);
    chk("rehunt_state", {29'd0, sync_state}, 1);

    n = 0;
    do begin step(1, 4'h0, DD); n++; end while (!gt_rx_rst_req && n < 200);
    chk("tmo2_cycles", n, 100);
    chk("gt_rst_cnt2", {24'd0, gt_rst_cnt}, 2);
    step(1, 4'h0, DD);
    step(1, 4'h0, DD);
    #2 rstn = 0;
    #1;
    chk("async_abort", {23'd0, gt_rx_rst_req, sync_state, gt_rst_cnt}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
